// File: rtl/uart_pkg.sv
// Shared definitions for the monitor UART receive path: FSM encoding,
// oversampling constants and the 18-bit word layout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVS         = 16;
  localparam int unsigned MID         = 8;
  localparam int unsigned FRAME_BYTES = 3;
  localparam int unsigned WORD_W      = 18;

  // Frame 2 contributes only its two low data bits to the top of the word.
  function automatic logic [WORD_W-1:0] assemble_word(input logic [7:0] byte0,
                                                      input logic [7:0] byte1,
                                                      input logic [1:0] top);
    return {top, byte1, byte0};
  endfunction

endpackage

// File: rtl/uart_receive_if.sv
// Word delivery handshake between the UART receiver (master) and the
// monitor command logic (slave).
interface uart_receive_if;
  import uart_pkg::*;

  logic              rx_req;
  logic              rx_ack;
  logic [WORD_W-1:0] rx_dat;
  logic              rx_ferr;
  logic              rx_ovr;

  modport master (output rx_req, rx_dat, rx_ferr, rx_ovr, input rx_ack);
  modport slave  (input rx_req, rx_dat, rx_ferr, rx_ovr, output rx_ack);

endinterface

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-clk strobe every TICK_DIV clocks and a
// 4-bit phase within the bit; restart realigns both to a start edge.
module uart_rx_tick #(
  parameter int unsigned TICK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       restart,
  output logic       tick,
  output logic [3:0] ph
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_r;

  assign tick = (div_r == DIV_LAST);

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // sees the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      div_r <= '0;
      ph    <= '0;
    end else if (restart) begin
      div_r <= '0;
      ph    <= '0;
    end else if (tick) begin
      div_r <= '0;
      ph    <= ph + 4'd1;
    end else begin
      div_r <= div_r + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// Three-frame, 18-bit word UART receiver with 16x oversampling and a req/ack
// output handshake. Optional idle timeout: define UART_RX_TIMEOUT_EN.
module uart_receive
  import uart_pkg::*;
#(
  parameter int unsigned TICK_DIV = 13,
  parameter int unsigned TO_BITS  = 32
) (
  input  logic           clk,
  input  logic           rst_x,
  input  logic           uart_sin,
  uart_receive_if.master rx
);

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  rx_state_e  state;
  logic [1:0] byte_r;
  logic [2:0] bit_r;
  logic [7:0] sh_r;
  logic [7:0] byte0_r;
  logic [7:0] byte1_r;

  logic       sin_m;
  logic       sin_s;
  logic       sin_d;
  logic       tick;
  logic [3:0] ph_r;
  logic       start_det;
  logic       sample;
  logic       ack_take;
  logic       to_expire;

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // all idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      sin_m <= 1'b1;
      sin_s <= 1'b1;
      sin_d <= 1'b1;
    end else begin
      sin_m <= uart_sin;
      sin_s <= sin_m;
      sin_d <= sin_s;
    end
  end

  assign start_det = (state == IDLE) && sin_d && !sin_s;

  uart_rx_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_x   (rst_x),
    .restart (start_det),
    .tick    (tick),
    .ph      (ph_r)
  );

  // The tick that advances the phase to MID lands at the bit centre.
  assign sample   = tick && (ph_r == 4'(MID - 1));
  assign ack_take = rx.rx_ack && rx.rx_req;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_TICKS = TO_BITS * OVS;
  localparam int unsigned TO_W     = $clog2(TO_TICKS + 1);

  logic [TO_W-1:0] to_cnt;

  // Counts idle-high ticks while a partial word is pending.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      to_cnt <= '0;
    end else if (state != IDLE || byte_r == 2'd0 || start_det || !sin_s) begin
      to_cnt <= '0;
    end else if (tick && !to_expire) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_expire = (to_cnt == TO_W'(TO_TICKS));
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state      <= IDLE;
      byte_r     <= '0;
      bit_r      <= '0;
      sh_r       <= '0;
      byte0_r    <= '0;
      byte1_r    <= '0;
      rx.rx_req  <= 1'b0;
      rx.rx_dat  <= '0;
      rx.rx_ferr <= 1'b0;
      rx.rx_ovr  <= 1'b0;
    end else begin
      rx.rx_ferr <= 1'b0;
      rx.rx_ovr  <= 1'b0;
      if (ack_take) rx.rx_req <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_det)      state  <= START;
          else if (to_expire) byte_r <= '0;
        end

        START: begin
          if (sample) begin
            if (sin_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              bit_r <= '0;
            end
          end
        end

        DATA: begin
          if (sample) begin
            sh_r  <= {sin_s, sh_r[7:1]};
            bit_r <= bit_r + 3'd1;
            if (bit_r == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          if (sample) begin
            state <= IDLE;
            if (!sin_s) begin
              rx.rx_ferr <= 1'b1;
              byte_r     <= '0;
            end else if (byte_r != LAST_BYTE) begin
              if (byte_r == 2'd0) byte0_r <= sh_r;
              else                byte1_r <= sh_r;
              byte_r <= byte_r + 2'd1;
            end else begin
              byte_r <= '0;
              if (sh_r[7:2] != 6'd0) begin
                rx.rx_ferr <= 1'b1;
              end else if (rx.rx_req && !rx.rx_ack) begin
                rx.rx_ovr <= 1'b1;
              end else begin
                // A same-cycle ack frees the slot, so the new word wins.
                rx.rx_dat <= assemble_word(byte0_r, byte1_r, sh_r[1:0]);
                rx.rx_req <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: frame-level word model plus a per-cycle
// compare process, and literal expectations for the documented scenarios.
module tb_uart_receive;
  import uart_pkg::*;

  localparam int TICK_DIV = 13;
  localparam int TO_BITS  = 32;
  localparam int BIT_CLK  = OVS * TICK_DIV;
  // Stop-bit centre relative to the cycle the start bit is driven:
  // two synchroniser flops, one edge-detect cycle, then 9.5 bit times.
  localparam int STOP_SAMPLE = 3 + TICK_DIV * (OVS * 9 + MID);

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic uart_sin = 1'b1;

  uart_receive_if rx_if ();

  uart_receive #(.TICK_DIV(TICK_DIV), .TO_BITS(TO_BITS)) dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .uart_sin (uart_sin),
    .rx       (rx_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic              exp_req = 1'b0;
  logic [WORD_W-1:0] exp_dat = '0;
  int                exp_idx = 0;
  logic [7:0]        part [2];

  bit active    = 1'b0;
  bit in_window = 1'b0;
  int ferr_seen = 0;
  int ovr_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (rx_if.rx_ferr) ferr_seen++;
      if (rx_if.rx_ovr)  ovr_seen++;
      if (!in_window) begin
        check("cyc_req",  32'(rx_if.rx_req),  32'(exp_req));
        check("cyc_dat",  32'(rx_if.rx_dat),  32'(exp_dat));
        check("cyc_ferr", 32'(rx_if.rx_ferr), 32'd0);
        check("cyc_ovr",  32'(rx_if.rx_ovr),  32'd0);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int nbits);
    uart_sin = 1'b1;
    step(nbits * BIT_CLK);
`ifdef UART_RX_TIMEOUT_EN
    if (nbits >= TO_BITS + 2) exp_idx = 0;
`endif
  endtask

  // One frame: start bit, 8 data bits LSB first, first stop bit = stop_ok,
  // remaining stop bits high. Optionally acks in the completion cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int nstop, input bit ack_done);
    int   exp_f;
    int   exp_o;
    bit   loaded;
    int   idx;
    logic v;
    for (int c = 0; c < BIT_CLK * (9 + nstop); c++) begin
      idx = c / BIT_CLK;
      if (idx == 0)      v = 1'b0;
      else if (idx <= 8) v = b[idx-1];
      else if (idx == 9) v = stop_ok;
      else               v = 1'b1;
      uart_sin = v;
      if (c == BIT_CLK * 9) begin
        in_window = 1'b1;
        ferr_seen = 0;
        ovr_seen  = 0;
      end
      if (ack_done) rx_if.rx_ack = (c == STOP_SAMPLE - 1);
      @(posedge clk);
      #1;
    end
    rx_if.rx_ack = 1'b0;

    exp_f  = 0;
    exp_o  = 0;
    loaded = 1'b0;
    if (!stop_ok) begin
      exp_f   = 1;
      exp_idx = 0;
    end else if (exp_idx < FRAME_BYTES - 1) begin
      part[exp_idx] = b;
      exp_idx++;
    end else begin
      exp_idx = 0;
      if (b[7:2] != 6'd0) begin
        exp_f = 1;
      end else if (exp_req && !ack_done) begin
        exp_o = 1;
      end else begin
        exp_dat = {b[1:0], part[1], part[0]};
        exp_req = 1'b1;
        loaded  = 1'b1;
      end
    end
    if (ack_done && !loaded) exp_req = 1'b0;

    check("frame_ferr_pulses", 32'(ferr_seen), 32'(exp_f));
    check("frame_ovr_pulses",  32'(ovr_seen),  32'(exp_o));
    in_window = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nstop, input bit ack_last);
    send_frame(b0, 1'b1, nstop, 1'b0);
    send_frame(b1, 1'b1, nstop, 1'b0);
    send_frame(b2, 1'b1, nstop, ack_last);
    idle_bits(1);
  endtask

  task automatic do_ack();
    rx_if.rx_ack = 1'b1;
    step(1);
    rx_if.rx_ack = 1'b0;
    exp_req = 1'b0;
    step(2);
  endtask

  initial begin
    rx_if.rx_ack = 1'b0;

    // Reset state
    step(4);
    check("rst_req",  32'(rx_if.rx_req),  32'd0);
    check("rst_dat",  32'(rx_if.rx_dat),  32'd0);
    check("rst_ferr", 32'(rx_if.rx_ferr), 32'd0);
    check("rst_ovr",  32'(rx_if.rx_ovr),  32'd0);
    rst_x = 1'b1;
    active = 1'b1;
    idle_bits(2);

    // Ack without a pending word is ignored
    do_ack();

    // Nominal word, two stop bits
    send_word(8'h5A, 8'hC3, 8'h02, 2, 1'b0);
    check("nominal_req", 32'(rx_if.rx_req), 32'd1);
    check("nominal_dat", 32'(rx_if.rx_dat), 32'h2C35A);
    do_ack();
    check("nominal_ack_req", 32'(rx_if.rx_req), 32'd0);

    // Short low glitch in idle, then a back-to-back word
    uart_sin = 1'b0;
    step(3 * TICK_DIV);
    idle_bits(2);
    send_word(8'h3C, 8'h96, 8'h01, 1, 1'b0);
    check("glitch_word_dat", 32'(rx_if.rx_dat), 32'h1963C);
    do_ack();

    // Framing error on frame 1, then a clean word
    send_frame(8'h55, 1'b1, 2, 1'b0);
    send_frame(8'hAA, 1'b0, 2, 1'b0);
    idle_bits(1);
    check("ferr_no_req", 32'(rx_if.rx_req), 32'd0);
    send_word(8'h01, 8'h00, 8'h03, 1, 1'b0);
    check("ferr_next_dat", 32'(rx_if.rx_dat), 32'h30001);
    do_ack();

    // Format error: frame 2 has non-zero upper bits
    send_word(8'h11, 8'h22, 8'h84, 1, 1'b0);
    check("fmt_req", 32'(rx_if.rx_req), 32'd0);
    check("fmt_dat", 32'(rx_if.rx_dat), 32'h30001);

    // Overrun, then ack in the completion cycle
    send_word(8'h0F, 8'hF0, 8'h01, 1, 1'b0);
    check("ovr_first_dat", 32'(rx_if.rx_dat), 32'h1F00F);
    send_word(8'h12, 8'h34, 8'h02, 1, 1'b0);
    check("ovr_kept_dat", 32'(rx_if.rx_dat), 32'h1F00F);
    check("ovr_kept_req", 32'(rx_if.rx_req), 32'd1);
    send_word(8'hAB, 8'hCD, 8'h03, 1, 1'b1);
    check("ack_same_dat", 32'(rx_if.rx_dat), 32'h3CDAB);
    check("ack_same_req", 32'(rx_if.rx_req), 32'd1);

    // Reset in the middle of a partially received word
    send_frame(8'h11, 1'b1, 1, 1'b0);
    uart_sin = 1'b0;
    step(3 * BIT_CLK);
    active = 1'b0;
    rst_x  = 1'b0;
    step(2);
    check("midrst_req", 32'(rx_if.rx_req), 32'd0);
    check("midrst_dat", 32'(rx_if.rx_dat), 32'd0);
    exp_req  = 1'b0;
    exp_dat  = '0;
    exp_idx  = 0;
    uart_sin = 1'b1;
    step(3);
    rst_x  = 1'b1;
    active = 1'b1;
    idle_bits(2);
    send_word(8'h44, 8'h55, 8'h00, 1, 1'b0);
    check("midrst_word", 32'(rx_if.rx_dat), 32'h05544);
    do_ack();

    // Long idle after a lone frame 0
    send_frame(8'hAA, 1'b1, 1, 1'b0);
    idle_bits(40);
    send_word(8'h12, 8'h01, 8'h02, 1, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout_dat", 32'(rx_if.rx_dat), 32'h20112);
`else
    check("stale_dat", 32'(rx_if.rx_dat), 32'h112AA);
`endif
    check("timeout_req", 32'(rx_if.rx_req), 32'd1);
    do_ack();

    active = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
